pet_status_fsm: RTL and testbench
=================================

# pet_status_fsm

Pet-status core of the tamagotchi: consumes the debounced, active-low button levels produced by the button driver (`food_signal`, `heal_signal`, `test_signal`), turns them into single-cycle press events, and maintains saturating food and health levels that decay on a periodic tick. It derives the pet's mood state (HAPPY / HUNGRY / SICK / DEAD) for the display and LED stages downstream. Test mode accelerates the decay tick for demonstrations.

## Interface

- `CLK_FREQ`, 50_000_000, clock frequency in Hz
- `TICK_SEC`, 10, normal decay period in seconds
- `TEST_DIV`, 10, decay speed-up factor in test mode; must be ≥1 and divide `CLK_FREQ*TICK_SEC`
- `MAX_LEVEL`, 5, saturation value of both levels (3-bit field, ≤7)
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `food_signal`  in  1  feed button, active-low level, already debounced and synchronous to `clk`
- `heal_signal`  in  1  heal button, active-low level, same properties
- `test_signal`  in  1  test button, active-low level, same properties
- `food_level`  out  3  current food level, 0..MAX_LEVEL
- `health_level`  out  3  current health level, 0..MAX_LEVEL
- `state`  out  2  HAPPY=0, HUNGRY=1, SICK=2, DEAD=3
- `test_active`  out  1  1 while accelerated test mode is on
- `feed_ack`  out  1  one-cycle pulse when a feed press is accepted
- `heal_ack`  out  1  one-cycle pulse when a heal press is accepted

## Operation

- Press detection: each button input is registered every cycle (previous-value flops reset to 1). A press is current=0 and previous=1. Holding a button low yields exactly one press.
- Tick generator: counter counts 0..PERIOD-1, where PERIOD = `CLK_FREQ*TICK_SEC` (normal) or `CLK_FREQ*TICK_SEC/TEST_DIV` (test). Tick is asserted in the cycle the counter equals PERIOD-1; the counter then wraps to 0. Counter width is `$clog2(CLK_FREQ*TICK_SEC)`.
- Test press: toggles `test_active` and clears the tick counter to 0; no tick is issued in that cycle. Test presses are honoured in every state, including DEAD.
- On tick, when not DEAD: `food_level` decrements, saturating at 0. If `food_level` was 0 before the tick, `health_level` decrements instead, saturating at 0.
- Feed press, when not DEAD: `food_level` increments, saturating at MAX_LEVEL. `feed_ack` pulses even when the level is already saturated.
- Heal press, when not DEAD: `health_level` increments, saturating at MAX_LEVEL. `heal_ack` pulses.
- Simultaneous tick and press on the same level: the press wins and the tick's decrement of that level is dropped. The other level still follows the tick rules.
- State, decoded from next-cycle levels and registered with them, priority top-down:
  - DEAD if health=0
  - SICK if health<3
  - HUNGRY if food<3
  - HAPPY otherwise
- DEAD is absorbing:
  - levels are frozen and ticks are ignored
  - feed/heal presses are ignored and produce no ack
  - only `reset` leaves DEAD
- Reset values:
  - `food_level` = `health_level` = MAX_LEVEL
  - `state` = HAPPY
  - `test_active` = 0, `feed_ack` = `heal_ack` = 0
  - tick counter = 0, press-detect flops = 1
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge. A button held low through reset release produces no press.

## Timing

- Button input first sampled low at edge k: the level update, ack and state all appear after edge k, so they are visible in cycle k+1.
- `feed_ack` and `heal_ack` are high for exactly one cycle.
- Tick to level change: the level changes on the same edge the counter wraps.
- Normal mode: first tick arrives PERIOD cycles after reset release or after a test toggle.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan

Bench uses `CLK_FREQ=10`, `TICK_SEC=1`, `TEST_DIV=5`, `MAX_LEVEL=5`, giving a tick every 10 cycles in normal mode and every 2 in test mode.

- Reset, then idle for 50 cycles -> food steps 5→0 at cycles 10,20,…,50; health stays 5; state becomes HUNGRY when food reaches 2.
- Continue idling -> health decrements every 10 cycles; SICK at health=2; DEAD at health=0; levels then frozen at 0/0 and ticks ignored.
- In DEAD, press feed and heal -> no ack, levels unchanged. Press test -> `test_active` toggles. Assert `reset` -> 5/5, HAPPY.
- Hold `food_signal` low for 30 cycles at food=3 -> exactly one `feed_ack`, food=4. Feed again twice -> food saturates at 5, both presses acked.
- Feed press in the same cycle as a tick, with food=3 -> food=4; the tick's decrement is dropped.
- Test press at counter=7 -> counter clears, `test_active`=1, next tick after 2 cycles. Test press again -> normal 10-cycle period resumes from 0.

Source files
------------

// File: rtl/pet_status_fsm.sv
// Pet-status core: turns debounced active-low buttons into press events and keeps
// saturating food/health levels that decay on a periodic tick, plus the derived mood.
module pet_status_fsm #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_SEC  = 10,
  parameter int unsigned TEST_DIV  = 10,
  parameter int unsigned MAX_LEVEL = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       food_signal,
  input  logic       heal_signal,
  input  logic       test_signal,
  output logic [2:0] food_level,
  output logic [2:0] health_level,
  output logic [1:0] state,
  output logic       test_active,
  output logic       feed_ack,
  output logic       heal_ack
);

  localparam int unsigned PeriodNorm = CLK_FREQ * TICK_SEC;
  localparam int unsigned PeriodTest = PeriodNorm / TEST_DIV;
  localparam int unsigned CntW       = (PeriodNorm > 1) ? $clog2(PeriodNorm) : 1;

  localparam logic [CntW-1:0] LastNorm = CntW'(PeriodNorm - 1);
  localparam logic [CntW-1:0] LastTest = CntW'(PeriodTest - 1);
  localparam logic [2:0]      MaxLvl   = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    StHappy  = 2'd0,
    StHungry = 2'd1,
    StSick   = 2'd2,
    StDead   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      food_q, food_d;
  logic [2:0]      health_q, health_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            test_q, test_d;
  logic            feed_ack_q, feed_ack_d;
  logic            heal_ack_q, heal_ack_d;
  logic            food_prev_q, heal_prev_q, test_prev_q;
  logic            arm_q;

  logic food_press, heal_press, test_press;
  logic tick, dead;

  always_comb begin
    // arm_q masks the first edge after reset so a button held through release is not a press
    food_press = arm_q & food_prev_q & ~food_signal;
    heal_press = arm_q & heal_prev_q & ~heal_signal;
    test_press = arm_q & test_prev_q & ~test_signal;
    tick       = ~test_press & (cnt_q == (test_q ? LastTest : LastNorm));
    dead       = (state_q == StDead);

    cnt_d      = cnt_q + 1'b1;
    test_d     = test_q ^ test_press;
    food_d     = food_q;
    health_d   = health_q;
    feed_ack_d = 1'b0;
    heal_ack_d = 1'b0;
    state_d    = state_q;

    if (test_press || tick) begin
      cnt_d = '0;
    end

    if (!dead) begin
      // A press on a level overrides that level's tick decrement
      if (food_press) begin
        feed_ack_d = 1'b1;
        if (food_q < MaxLvl) food_d = food_q + 3'd1;
      end else if (tick && food_q != 3'd0) begin
        food_d = food_q - 3'd1;
      end

      if (heal_press) begin
        heal_ack_d = 1'b1;
        if (health_q < MaxLvl) health_d = health_q + 3'd1;
      end else if (tick && food_q == 3'd0 && health_q != 3'd0) begin
        health_d = health_q - 3'd1;
      end
    end

    if (health_d == 3'd0) begin
      state_d = StDead;
    end else if (health_d < 3'd3) begin
      state_d = StSick;
    end else if (food_d < 3'd3) begin
      state_d = StHungry;
    end else begin
      state_d = StHappy;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StHappy;
      food_q      <= MaxLvl;
      health_q    <= MaxLvl;
      cnt_q       <= '0;
      test_q      <= 1'b0;
      feed_ack_q  <= 1'b0;
      heal_ack_q  <= 1'b0;
      food_prev_q <= 1'b1;
      heal_prev_q <= 1'b1;
      test_prev_q <= 1'b1;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      food_q      <= food_d;
      health_q    <= health_d;
      cnt_q       <= cnt_d;
      test_q      <= test_d;
      feed_ack_q  <= feed_ack_d;
      heal_ack_q  <= heal_ack_d;
      food_prev_q <= food_signal;
      heal_prev_q <= heal_signal;
      test_prev_q <= test_signal;
      arm_q       <= 1'b1;
    end
  end

  assign food_level   = food_q;
  assign health_level = health_q;
  assign state        = state_q;
  assign test_active  = test_q;
  assign feed_ack     = feed_ack_q;
  assign heal_ack     = heal_ack_q;

endmodule

// File: tb/tb_pet_status_fsm.sv
// Directed bench for pet_status_fsm: tick every 10 cycles normally, every 2 in test mode.
module tb_pet_status_fsm;

  logic       clk;
  logic       reset;
  logic       food_signal, heal_signal, test_signal;
  logic [2:0] food_level, health_level;
  logic [1:0] state;
  logic       test_active, feed_ack, heal_ack;

  int n_checks = 0;
  int n_errors = 0;
  int ack_sum;

  int exp_food[10]   = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
  int exp_health[10] = '{5, 5, 5, 5, 5, 4, 3, 2, 1, 0};
  int exp_state[10]  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 3};
  int exp_feed[5]    = '{2, 3, 4, 5, 5};

  pet_status_fsm #(
    .CLK_FREQ (10),
    .TICK_SEC (1),
    .TEST_DIV (5),
    .MAX_LEVEL(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .food_signal (food_signal),
    .heal_signal (heal_signal),
    .test_signal (test_signal),
    .food_level  (food_level),
    .health_level(health_level),
    .state       (state),
    .test_active (test_active),
    .feed_ack    (feed_ack),
    .heal_ack    (heal_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    food_signal = 1'b1;
    heal_signal = 1'b1;
    test_signal = 1'b1;
    #2 reset = 1'b0;
    #10;
    check_eq("rst_food", int'(food_level), 5);
    check_eq("rst_health", int'(health_level), 5);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_test", int'(test_active), 0);
    check_eq("rst_feed_ack", int'(feed_ack), 0);
    check_eq("rst_heal_ack", int'(heal_ack), 0);
    @(negedge clk);
    reset = 1'b1;

    // Idle decay all the way to DEAD
    for (int i = 0; i < 10; i++) begin
      repeat (10) step();
      check_eq($sformatf("decay_food_%0d", i), int'(food_level), exp_food[i]);
      check_eq($sformatf("decay_health_%0d", i), int'(health_level), exp_health[i]);
      check_eq($sformatf("decay_state_%0d", i), int'(state), exp_state[i]);
    end
    repeat (20) step();
    check_eq("dead_frozen_food", int'(food_level), 0);
    check_eq("dead_frozen_health", int'(health_level), 0);
    check_eq("dead_frozen_state", int'(state), 3);

    // Presses in DEAD
    food_signal = 1'b0;
    step();
    check_eq("dead_feed_ack", int'(feed_ack), 0);
    check_eq("dead_feed_food", int'(food_level), 0);
    food_signal = 1'b1;
    heal_signal = 1'b0;
    step();
    check_eq("dead_heal_ack", int'(heal_ack), 0);
    check_eq("dead_heal_health", int'(health_level), 0);
    heal_signal = 1'b1;
    test_signal = 1'b0;
    step();
    check_eq("dead_test_toggle", int'(test_active), 1);
    check_eq("dead_still_dead", int'(state), 3);
    test_signal = 1'b1;
    step();

    // Asynchronous reset with feed held low through release
    food_signal = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("async_rst_food", int'(food_level), 5);
    check_eq("async_rst_health", int'(health_level), 5);
    check_eq("async_rst_state", int'(state), 0);
    check_eq("async_rst_test", int'(test_active), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_eq("held_rst_ack1", int'(feed_ack), 0);
    step();
    check_eq("held_rst_ack2", int'(feed_ack), 0);
    food_signal = 1'b1;
    repeat (18) step();
    check_eq("pre_hold_food", int'(food_level), 3);
    check_eq("pre_hold_state", int'(state), 0);

    // Long hold yields one press
    food_signal = 1'b0;
    step();
    check_eq("hold_ack", int'(feed_ack), 1);
    check_eq("hold_food", int'(food_level), 4);
    ack_sum = 0;
    for (int i = 0; i < 29; i++) begin
      step();
      ack_sum += int'(feed_ack);
    end
    check_eq("hold_extra_acks", ack_sum, 0);
    check_eq("hold_end_food", int'(food_level), 1);
    food_signal = 1'b1;
    step();

    // Repeated feeds up to saturation; last one coincides with a tick
    for (int k = 0; k < 5; k++) begin
      food_signal = 1'b0;
      step();
      check_eq($sformatf("feed_ack_%0d", k), int'(feed_ack), 1);
      check_eq($sformatf("feed_food_%0d", k), int'(food_level), exp_feed[k]);
      food_signal = 1'b1;
      step();
      check_eq($sformatf("feed_ack_low_%0d", k), int'(feed_ack), 0);
    end
    check_eq("sat_health", int'(health_level), 5);

    // Feed on a tick edge with food=3
    repeat (28) step();
    check_eq("pre_tick_feed_food", int'(food_level), 3);
    food_signal = 1'b0;
    step();
    check_eq("tick_feed_food", int'(food_level), 4);
    check_eq("tick_feed_ack", int'(feed_ack), 1);
    check_eq("tick_feed_health", int'(health_level), 5);
    food_signal = 1'b1;

    // Test press at counter=7
    repeat (7) step();
    test_signal = 1'b0;
    step();
    check_eq("test_on", int'(test_active), 1);
    test_signal = 1'b1;
    step();
    check_eq("test_no_tick_yet", int'(food_level), 4);
    step();
    check_eq("test_first_tick", int'(food_level), 3);

    // Back to normal period
    test_signal = 1'b0;
    step();
    check_eq("test_off", int'(test_active), 0);
    test_signal = 1'b1;
    repeat (9) step();
    check_eq("normal_no_tick_yet", int'(food_level), 3);
    step();
    check_eq("normal_tick_food", int'(food_level), 2);
    check_eq("normal_tick_state", int'(state), 1);

    // Heal below saturation, then tick drops health again
    test_signal = 1'b0;
    step();
    check_eq("test_on2", int'(test_active), 1);
    test_signal = 1'b1;
    repeat (6) step();
    check_eq("fast_food", int'(food_level), 0);
    check_eq("fast_health", int'(health_level), 4);
    heal_signal = 1'b0;
    step();
    check_eq("heal_health", int'(health_level), 5);
    check_eq("heal_ack", int'(heal_ack), 1);
    heal_signal = 1'b1;
    step();
    check_eq("heal_ack_low", int'(heal_ack), 0);
    check_eq("post_heal_tick_health", int'(health_level), 4);
    check_eq("post_heal_state", int'(state), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
